// File: rtl/vending_machine_param.sv
// Parametrised Moore vending controller: accumulates coin credit up to PRICE,
// pulses sell for one cycle, then pays back any surplus one unit per cycle.
module vending_machine_param #(
    parameter int PRICE     = 4,
    parameter int COIN0_VAL = 1,
    parameter int COIN1_VAL = 2,
    parameter int COIN2_VAL = 4,
    parameter int CREDIT_W  = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic                sell,
    output logic                change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state_dbg
);

    // Handshake: coin_valid and cancel are single-cycle strobes sampled on the
    // rising edge; there is no ready, so a coin that cannot be taken is answered
    // by coin_reject one cycle later instead of being held off.

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic [CREDIT_W:0]   coin_amt;
    logic [CREDIT_W:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_COLLECT;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        coin_amt = '0;
        case (coin_type)
            2'd0:    coin_amt = (CREDIT_W+1)'(COIN0_VAL);
            2'd1:    coin_amt = (CREDIT_W+1)'(COIN1_VAL);
            2'd2:    coin_amt = (CREDIT_W+1)'(COIN2_VAL);
            default: coin_amt = '0;
        endcase
        sum = {1'b0, credit_q} + coin_amt;

        case (state_q)
            S_COLLECT: begin
                // A cancel outranks a coin in the same cycle; that coin is bounced.
                if (cancel) begin
                    reject_d = coin_valid;
                    if (credit_q != '0) state_d = S_CHANGE;
                end else if (coin_valid) begin
                    if (coin_type == 2'd3) begin
                        reject_d = 1'b1;
                    end else if (sum >= PRICE_X) begin
                        credit_d = CREDIT_W'(sum - PRICE_X);
                        state_d  = S_VEND;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_valid;
                state_d  = (credit_q != '0) ? S_CHANGE : S_COLLECT;
            end
            S_CHANGE: begin
                reject_d = coin_valid;
                if (credit_q != '0) credit_d = credit_q - CREDIT_W'(1);
                if (credit_q <= CREDIT_W'(1)) state_d = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase
    end

    assign sell        = (state_q == S_VEND);
    assign change      = (state_q == S_CHANGE);
    assign busy        = sell | change;
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: scenario tasks plus random traffic, with a
// schedule-based reference model (each vend/refund expands into a queue of busy cycles).
module tb_vending_machine_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cv4, cn4, cv7, cn7;
    logic [1:0] ct4, ct7;
    logic       sell4, chg4, rej4, busy4, sell7, chg7, rej7, busy7;
    logic [8:0] credit4, credit7;
    logic [1:0] st4, st7;

    vending_machine_param #(.PRICE(4)) dut (
        .clk(clk), .rst(rst), .coin_valid(cv4), .coin_type(ct4), .cancel(cn4),
        .sell(sell4), .change(chg4), .coin_reject(rej4), .busy(busy4),
        .credit(credit4), .state_dbg(st4)
    );

    vending_machine_param #(.PRICE(7)) dut7 (
        .clk(clk), .rst(rst), .coin_valid(cv7), .coin_type(ct7), .cancel(cn7),
        .sell(sell7), .change(chg7), .coin_reject(rej7), .busy(busy7),
        .credit(credit7), .state_dbg(st7)
    );

    typedef struct packed {
        logic       sell;
        logic       change;
        logic [8:0] credit;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    bit   sel = 1'b0;
    int   m_price = 4;
    int   m_credit = 0;
    bit   m_reject = 1'b0;
    ent_t sched[$];
    int   n_sell, n_change, n_busy, n_reject;

    function automatic int coin_val(input int t);
        return (t == 0) ? 1 : (t == 1) ? 2 : 4;
    endfunction

    function automatic ent_t mk(input logic s, input logic c, input int cr);
        ent_t e;
        e.sell = s;
        e.change = c;
        e.credit = 9'(cr);
        return e;
    endfunction

    // {sell, change, busy, coin_reject, credit}
    function automatic logic [12:0] expv();
        if (sched.size() > 0)
            return {sched[0].sell, sched[0].change, 1'b1, m_reject, sched[0].credit};
        return {3'b000, m_reject, 9'(m_credit)};
    endfunction

    function automatic logic [12:0] obsv();
        if (sel) return {sell7, chg7, busy7, rej7, credit7};
        return {sell4, chg4, busy4, rej4, credit4};
    endfunction

    task automatic model_clear();
        sched.delete();
        m_credit = 0;
        m_reject = 1'b0;
    endtask

    task automatic clear_counts();
        n_sell = 0; n_change = 0; n_busy = 0; n_reject = 0;
    endtask

    task automatic step(input bit cv, input int ct, input bit cn);
        logic [12:0] o;
        int sum;
        bit was_busy;
        cv4 = sel ? 1'b0 : cv;  ct4 = sel ? 2'd0 : 2'(ct);  cn4 = sel ? 1'b0 : cn;
        cv7 = sel ? cv : 1'b0;  ct7 = sel ? 2'(ct) : 2'd0;  cn7 = sel ? cn : 1'b0;
        @(posedge clk);
        #1;
        was_busy = (sched.size() > 0);
        m_reject = cv && (was_busy || ct == 3 || cn);
        if (was_busy) begin
            void'(sched.pop_front());
        end else if (cn) begin
            for (int c = m_credit; c > 0; c--) sched.push_back(mk(1'b0, 1'b1, c));
            m_credit = 0;
        end else if (cv && ct != 3) begin
            sum = m_credit + coin_val(ct);
            if (sum >= m_price) begin
                sched.push_back(mk(1'b1, 1'b0, sum - m_price));
                for (int c = sum - m_price; c > 0; c--) sched.push_back(mk(1'b0, 1'b1, c));
                m_credit = 0;
            end else begin
                m_credit = sum;
            end
        end
        o = obsv();
        n_sell += int'(o[12]); n_change += int'(o[11]);
        n_busy += int'(o[10]); n_reject += int'(o[9]);
        cv4 = 1'b0; ct4 = 2'd0; cn4 = 1'b0;
        cv7 = 1'b0; ct7 = 2'd0; cn7 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cv4 = 1'b0; ct4 = 2'd0; cn4 = 1'b0;
        cv7 = 1'b0; ct7 = 2'd0; cn7 = 1'b0;
        #1;
        checks++;
        if ({sell4, chg4, busy4, rej4, credit4} !== 13'd0) begin
            errors++;
            $display("FAIL reset_p4 got=%h exp=0", {sell4, chg4, busy4, rej4, credit4});
        end
        checks++;
        if ({sell7, chg7, busy7, rej7, credit7} !== 13'd0) begin
            errors++;
            $display("FAIL reset_p7 got=%h exp=0", {sell7, chg7, busy7, rej7, credit7});
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_exact_price();
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            step(i < 4, 0, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL exact_price cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (n_sell !== 1 || n_change !== 0 || credit4 !== 9'd0) begin
            errors++;
            $display("FAIL exact_price_counts sell=%0d change=%0d credit=%0d exp 1/0/0",
                     n_sell, n_change, credit4);
        end
    endtask

    task automatic test_overpay();
        int ts[2] = '{1, 2};
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            step(i < 2, (i < 2) ? ts[i] : 0, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL overpay cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (n_sell !== 1 || n_change !== 2 || n_busy !== 3) begin
            errors++;
            $display("FAIL overpay_counts sell=%0d change=%0d busy=%0d exp 1/2/3",
                     n_sell, n_change, n_busy);
        end
    endtask

    task automatic test_cancel();
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 1, i == 1);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL cancel cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (n_sell !== 0 || n_change !== 2 || credit4 !== 9'd0) begin
            errors++;
            $display("FAIL cancel_counts sell=%0d change=%0d credit=%0d exp 0/2/0",
                     n_sell, n_change, credit4);
        end
    endtask

    task automatic test_reject();
        // {coin_valid, coin_type, cancel} per cycle
        int cvs[12] = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        int cts[12] = '{3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int cns[12] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        clear_counts();
        for (int i = 0; i < 12; i++) begin
            step(cvs[i] != 0, cts[i], cns[i] != 0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL reject cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (n_reject !== 3 || n_change !== 3 || n_sell !== 0) begin
            errors++;
            $display("FAIL reject_counts reject=%0d change=%0d sell=%0d exp 3/3/0",
                     n_reject, n_change, n_sell);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        checks++;
        if (obsv() !== expv() || credit4 !== 9'd1 || chg4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got=%h exp=%h", obsv(), expv());
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sell4, chg4, busy4, rej4, credit4} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_drop got=%h exp=0", {sell4, chg4, busy4, rej4, credit4});
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 0, 1'b0);
        checks++;
        if (obsv() !== expv() || credit4 !== 9'd1) begin
            errors++;
            $display("FAIL reset_mid_after got=%h exp=%h", obsv(), expv());
        end
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL random sel=%0d cyc=%0d got=%h exp=%h", sel, i, obsv(), expv());
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 0, 1'b0);
        checks++;
        if (obsv() !== expv() || obsv() !== 13'd0) begin
            errors++;
            $display("FAIL random_drain sel=%0d got=%h exp=0", sel, obsv());
        end
    endtask

    task automatic test_price7();
        sel = 1'b1;
        m_price = 7;
        model_clear();
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            step(i < 2, 2, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL price7 cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (n_sell !== 1 || n_change !== 1) begin
            errors++;
            $display("FAIL price7_counts sell=%0d change=%0d exp 1/1", n_sell, n_change);
        end
        clear_counts();
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        checks++;
        if (n_busy !== 0 || n_reject !== 0 || credit7 !== 9'd0) begin
            errors++;
            $display("FAIL price7_idle_cancel busy=%0d reject=%0d credit=%0d exp 0/0/0",
                     n_busy, n_reject, credit7);
        end
        test_random(300);
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_overpay();
        test_cancel();
        test_reject();
        test_reset_mid();
        test_random(400);
        test_price7();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
